// File: rtl/io_oc_pkg.sv
// rtl/io_oc_pkg.sv - channel state type and OC field helpers shared by the OC controller
package io_oc_pkg;

   typedef enum logic [1:0] {
      OC_IDLE   = 2'd0,
      OC_PEND   = 2'd1,
      OC_ACTIVE = 2'd2,
      OC_DRAIN  = 2'd3
   } oc_state_e;

   localparam int OC_MAXW  = 16;
   localparam int OC_IDX_W = 4;

   function automatic int oc_in_bit(int ocw);
      return ocw - 2;
   endfunction

   function automatic int oc_slow_bit(int ocw);
      return ocw - 1;
   endfunction

   function automatic logic oc_is_slow(logic [OC_MAXW-1:0] op, int ocw);
      return op[OC_IDX_W'(oc_slow_bit(ocw))];
   endfunction

endpackage

// File: rtl/io_oc_ctl_mc_if.sv
// rtl/io_oc_ctl_mc_if.sv - command, device and status bundle of the multi-channel OC controller
interface io_oc_ctl_mc_if #(
   parameter int NCH = 2,
   parameter int OCW = 4
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic               T0;
   logic               DS;
   logic [CHW-1:0]     cmd_ch;
   logic [OCW-1:0]     cmd_op;
   logic [NCH-1:0]     key_stop;
   logic [NCH-1:0]     dev_done;
   logic [NCH*OCW-1:0] oc;
   logic [NCH-1:0]     ready;
   logic [NCH-1:0]     fast_in;
   logic [NCH-1:0]     fast_out;
   logic [NCH-1:0]     slow_in;
   logic [NCH-1:0]     slow_out;
   logic [NCH-1:0]     fast_grant;
   logic [NCH-1:0]     timeout;
   logic               cmd_err;

   modport master (
      output T0, DS, cmd_ch, cmd_op, key_stop, dev_done,
      input  oc, ready, fast_in, fast_out, slow_in, slow_out, fast_grant, timeout, cmd_err
   );

   modport slave (
      input  T0, DS, cmd_ch, cmd_op, key_stop, dev_done,
      output oc, ready, fast_in, fast_out, slow_in, slow_out, fast_grant, timeout, cmd_err
   );

endinterface

// File: rtl/io_oc_rr_arb.sv
// rtl/io_oc_rr_arb.sv - round-robin owner selection for the shared fast path
module io_oc_rr_arb #(
   parameter int NCH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           busy,
   input  logic [NCH-1:0] req,
   output logic [NCH-1:0] gnt
);
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Scan starts at the pointer so the last winner goes to the back of the line.
   always_comb begin : p_pick
      int   idx;
      logic found;
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      if (en && !busy) begin
         for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!found && req[PW'(idx)]) begin
               found            = 1'b1;
               gnt[PW'(idx)]    = 1'b1;
               ptr_d            = PW'((idx + 1) % NCH);
            end
         end
      end
   end

endmodule

// File: rtl/io_oc_ctl_mc.sv
// rtl/io_oc_ctl_mc.sv - per-channel OC registers and control FSMs with arbitrated fast path and watchdog
module io_oc_ctl_mc
   import io_oc_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int OCW    = 4,
   parameter int TO_W   = 12,
   parameter int TO_LIM = 4000
) (
   input logic           CLOCK,
   input logic           rst_n,
   io_oc_ctl_mc_if.slave bus
);
   localparam int              CHW         = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int              OC_IN_BIT   = oc_in_bit(OCW);
   localparam int              OC_SLOW_BIT = oc_slow_bit(OCW);
   localparam logic [TO_W-1:0] WD_LAST     = TO_W'(TO_LIM - 1);

   logic [NCH-1:0] req_vec;
   logic [NCH-1:0] gnt_vec;
   logic [NCH-1:0] fg_vec;
   logic [NCH-1:0] rej_vec;
   logic           cmd_nz;
   logic           cmd_err_q;
   logic           cmd_err_d;

   assign cmd_nz = |bus.cmd_op;

   io_oc_rr_arb #(.NCH(NCH)) u_arb (
      .clk   (CLOCK),
      .rst_n (rst_n),
      .en    (bus.T0),
      .busy  (|fg_vec),
      .req   (req_vec),
      .gnt   (gnt_vec)
   );

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      oc_state_e       st_q, st_d;
      logic [OCW-1:0]  oc_q, oc_d;
      logic [TO_W-1:0] wd_q, wd_d;
      logic            to_q, to_d;
      logic            fg_q, fg_d;
      logic            hit, stop, expire;
      logic            rdy, live, slow, dir_in;

      assign hit    = bus.DS && (bus.cmd_ch == CHW'(g));
      assign expire = (st_q == OC_ACTIVE) && bus.T0 && (wd_q >= WD_LAST);
      assign stop   = bus.key_stop[g] || (hit && !cmd_nz) || expire;

      // A channel being stopped this cycle must not win the fast path.
      assign req_vec[g] = (st_q == OC_PEND) && !stop;
      assign rej_vec[g] = hit && cmd_nz && ((st_q != OC_IDLE) || bus.key_stop[g]);
      assign fg_vec[g]  = fg_q;

      always_ff @(posedge CLOCK or negedge rst_n) begin
         if (!rst_n) begin
            st_q <= OC_IDLE;
            oc_q <= '0;
            wd_q <= '0;
            to_q <= 1'b0;
            fg_q <= 1'b0;
         end else begin
            st_q <= st_d;
            oc_q <= oc_d;
            wd_q <= wd_d;
            to_q <= to_d;
            fg_q <= fg_d;
         end
      end

      always_comb begin
         st_d = st_q;
         oc_d = oc_q;
         wd_d = wd_q;
         to_d = to_q;
         fg_d = fg_q;
         if ((st_q != OC_IDLE) && stop) begin
            st_d = OC_IDLE;
            oc_d = '0;
            fg_d = 1'b0;
            if (expire) begin
               to_d = 1'b1;
            end
         end else begin
            case (st_q)
               OC_IDLE: begin
                  if (hit && cmd_nz && !bus.key_stop[g]) begin
                     oc_d = bus.cmd_op;
                     to_d = 1'b0;
                     wd_d = '0;
                     st_d = oc_is_slow(OC_MAXW'(bus.cmd_op), OCW) ? OC_ACTIVE : OC_PEND;
                  end
               end
               OC_PEND: begin
                  if (gnt_vec[g]) begin
                     st_d = OC_ACTIVE;
                     fg_d = 1'b1;
                     wd_d = '0;
                  end
               end
               OC_ACTIVE: begin
                  if (bus.dev_done[g]) begin
                     st_d = OC_DRAIN;
                  end else if (bus.T0 && (wd_q != '1)) begin
                     wd_d = wd_q + 1'b1;
                  end
               end
               OC_DRAIN: begin
                  if (bus.T0) begin
                     st_d = OC_IDLE;
                     oc_d = '0;
                     fg_d = 1'b0;
                  end
               end
               default: st_d = OC_IDLE;
            endcase
         end
      end

      always_comb begin
         rdy    = (st_q == OC_IDLE);
         live   = (st_q == OC_ACTIVE) || (st_q == OC_DRAIN);
         slow   = oc_q[OC_SLOW_BIT];
         dir_in = oc_q[OC_IN_BIT];
      end

      assign bus.oc[g*OCW +: OCW] = oc_q;
      assign bus.ready[g]         = rdy;
      assign bus.fast_in[g]       = live && !slow && dir_in;
      assign bus.fast_out[g]      = live && !slow && !dir_in;
      assign bus.slow_in[g]       = live && slow && dir_in;
      assign bus.slow_out[g]      = live && slow && !dir_in;
      assign bus.fast_grant[g]    = fg_q;
      assign bus.timeout[g]       = to_q;
   end

   always_comb begin
      cmd_err_d = 1'b0;
      if (bus.DS) begin
         cmd_err_d = (32'(bus.cmd_ch) >= 32'(NCH)) || (|rej_vec);
      end
   end

   always_ff @(posedge CLOCK or negedge rst_n) begin
      if (!rst_n) begin
         cmd_err_q <= 1'b0;
      end else begin
         cmd_err_q <= cmd_err_d;
      end
   end

   assign bus.cmd_err = cmd_err_q;

endmodule
